// File: rtl/t_state_sequencer.sv
// 6502-style T-state sequencer: timing states, opcode latch, interrupt entry.
// Define BRANCH_PENALTY_EN to add page-cross and taken-branch cycles.
module t_state_sequencer (
  input  logic       phi2,
  input  logic       RES_n,
  input  logic       RDY,
  input  logic [7:0] data_in,
  input  logic [2:0] cycles_req,
  input  logic       is_branch,
  input  logic       branch_taken,
  input  logic       page_cross,
  input  logic       NMI_n,
  input  logic       IRQ_n,
  input  logic       I_flag,
  output logic [6:0] T,
  output logic [7:0] OP,
  output logic [7:0] prevOP,
  output logic [2:0] activeInt,
  output logic       SYNC
);

  localparam logic [2:0] INT_NONE = 3'b000;
  localparam logic [2:0] INT_NMI  = 3'b001;
  localparam logic [2:0] INT_IRQ  = 3'b010;
  localparam logic [2:0] INT_RES  = 3'b100;

  typedef enum logic [2:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S0 = 3'd7
  } tstate_e;

  tstate_e    cyc, cyc_n;
  logic [2:0] len, len_n, len_eff, req_len;
  logic [7:0] op_n, prevop_n;
  logic [2:0] act_n;
  logic       nmi_pend, nmi_pend_n;
  logic       nmi_prev, nmi_edge;
  logic       br_tkn, br_tkn_n;
  logic       irq_req, last, can_int;
  logic       pen2, pen3;

`ifdef BRANCH_PENALTY_EN
  assign pen2 = (cyc == S2) && is_branch && branch_taken;
  assign pen3 = (cyc == S3) && page_cross && (br_tkn || !is_branch);
`else
  logic unused_pen;
  assign unused_pen = page_cross ^ br_tkn;
  assign pen2 = 1'b0;
  assign pen3 = 1'b0;
`endif

  // penalties stretch the current instruction before the end test
  assign len_eff = ((pen2 || pen3) && (len != 3'd7)) ?
                   len + 3'd1 : len;
  assign last     = (cyc == tstate_e'(len_eff));
  assign req_len  = (cycles_req < 3'd2) ? 3'd2 : cycles_req;
  assign nmi_edge = nmi_prev && !NMI_n;
  assign irq_req  = !IRQ_n && !I_flag;
  // the reset sequence always hands over to a normal fetch
  assign can_int  = !activeInt[2];

  always_comb begin
    cyc_n      = cyc;
    len_n      = len;
    op_n       = OP;
    prevop_n   = prevOP;
    act_n      = activeInt;
    br_tkn_n   = br_tkn;
    nmi_pend_n = nmi_pend || nmi_edge;
    if (RDY) begin
      len_n = len_eff;
      if (cyc == S2)
        br_tkn_n = is_branch && branch_taken;
      if (!last) begin
        cyc_n = tstate_e'(cyc + 3'd1);
      end else begin
        cyc_n    = S1;
        prevop_n = OP;
        br_tkn_n = 1'b0;
        if (can_int && (nmi_pend || nmi_edge)) begin
          op_n       = 8'h00;
          len_n      = 3'd7;
          act_n      = INT_NMI;
          nmi_pend_n = 1'b0;
        end else if (can_int && irq_req) begin
          op_n  = 8'h00;
          len_n = 3'd7;
          act_n = INT_IRQ;
        end else begin
          op_n  = data_in;
          len_n = req_len;
          act_n = INT_NONE;
        end
      end
    end
  end

  always_ff @(posedge phi2 or negedge RES_n) begin
    if (!RES_n) begin
      cyc       <= S1;
      len       <= 3'd7;
      OP        <= 8'h00;
      prevOP    <= 8'h00;
      activeInt <= INT_RES;
      nmi_pend  <= 1'b0;
      nmi_prev  <= 1'b1;
      br_tkn    <= 1'b0;
    end else begin
      cyc       <= cyc_n;
      len       <= len_n;
      OP        <= op_n;
      prevOP    <= prevop_n;
      activeInt <= act_n;
      nmi_pend  <= nmi_pend_n;
      nmi_prev  <= NMI_n;
      br_tkn    <= br_tkn_n;
    end
  end

  assign T = {cyc == S6, cyc == S5, cyc == S4,
              cyc == S3, cyc == S2, cyc == S1,
              cyc == S0};
  assign SYNC = (cyc == S1);

endmodule

// File: tb/tb_t_state_sequencer.sv
// Bench for t_state_sequencer: directed cycle-by-cycle expectations
// queued by the stimulus and checked by an independent monitor.
module tb_t_state_sequencer;

`ifdef BRANCH_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] NMI  = 3'b001;
  localparam logic [2:0] IRQ  = 3'b010;
  localparam logic [2:0] RST  = 3'b100;

  logic       phi2 = 1'b0;
  logic       RES_n;
  logic       RDY;
  logic [7:0] data_in;
  logic [2:0] cycles_req;
  logic       is_branch;
  logic       branch_taken;
  logic       page_cross;
  logic       NMI_n;
  logic       IRQ_n;
  logic       I_flag;
  logic [6:0] T;
  logic [7:0] OP;
  logic [7:0] prevOP;
  logic [2:0] activeInt;
  logic       SYNC;

  t_state_sequencer dut (
    .phi2        (phi2),
    .RES_n       (RES_n),
    .RDY         (RDY),
    .data_in     (data_in),
    .cycles_req  (cycles_req),
    .is_branch   (is_branch),
    .branch_taken(branch_taken),
    .page_cross  (page_cross),
    .NMI_n       (NMI_n),
    .IRQ_n       (IRQ_n),
    .I_flag      (I_flag),
    .T           (T),
    .OP          (OP),
    .prevOP      (prevOP),
    .activeInt   (activeInt),
    .SYNC        (SYNC)
  );

  always #5 phi2 = ~phi2;

  typedef struct {
    logic [6:0] t;
    logic [7:0] op;
    logic [7:0] pv;
    logic [2:0] act;
    logic       sync;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;

  // T[k] marks cycle k for 1..6, T[0] marks cycle 7
  function automatic logic [6:0] tk(input int k);
    logic [6:0] one;
    one = 7'd1;
    return one << (k % 7);
  endfunction

  task automatic nx(input int k, input logic [7:0] op,
                    input logic [7:0] pv, input logic [2:0] act);
    exp_t e;
    @(posedge phi2);
    #1;
    e.t    = tk(k);
    e.op   = op;
    e.pv   = pv;
    e.act  = act;
    e.sync = (k == 1);
    e.idx  = nstep;
    nstep  = nstep + 1;
    q.push_back(e);
  endtask

  task automatic run(input int a, input int b, input logic [7:0] op,
                     input logic [7:0] pv, input logic [2:0] act);
    for (int k = a; k <= b; k++)
      nx(k, op, pv, act);
  endtask

  always @(negedge phi2) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if (T !== m.t || OP !== m.op || prevOP !== m.pv ||
          activeInt !== m.act || SYNC !== m.sync) begin
        errors++;
        $display("FAIL step%0d: got T=%b OP=%h prevOP=%h act=%b SYNC=%b, want T=%b OP=%h prevOP=%h act=%b SYNC=%b",
                 m.idx, T, OP, prevOP, activeInt, SYNC,
                 m.t, m.op, m.pv, m.act, m.sync);
      end
    end
  end

  initial begin
    RES_n = 1'b0; RDY = 1'b1; data_in = 8'hFF; cycles_req = 3'd2;
    is_branch = 1'b0; branch_taken = 1'b0; page_cross = 1'b0;
    NMI_n = 1'b1; IRQ_n = 1'b1; I_flag = 1'b0;

    // reset hold and 7-cycle reset sequence
    nx(1, 8'h00, 8'h00, RST);
    nx(1, 8'h00, 8'h00, RST);
    RES_n = 1'b1;
    run(2, 7, 8'h00, 8'h00, RST);
    data_in = 8'hA9; cycles_req = 3'd2;
    nx(1, 8'hA9, 8'h00, NONE);
    nx(2, 8'hA9, 8'h00, NONE);

    // two-cycle instructions back to back
    data_in = 8'h69;
    nx(1, 8'h69, 8'hA9, NONE);
    nx(2, 8'h69, 8'hA9, NONE);
    data_in = 8'hEA;
    nx(1, 8'hEA, 8'h69, NONE);
    nx(2, 8'hEA, 8'h69, NONE);

    // LDA abx with page cross
    data_in = 8'hBD; cycles_req = 3'd4;
    nx(1, 8'hBD, 8'hEA, NONE);
    data_in = 8'hFF; cycles_req = 3'd2;
    run(2, 3, 8'hBD, 8'hEA, NONE);
    page_cross = 1'b1;
    nx(4, 8'hBD, 8'hEA, NONE);
    page_cross = 1'b0; data_in = 8'hD0; cycles_req = 3'd2;
    if (PEN) nx(5, 8'hBD, 8'hEA, NONE);
    nx(1, 8'hD0, 8'hBD, NONE);

    // taken branch crossing a page
    nx(2, 8'hD0, 8'hBD, NONE);
    is_branch = 1'b1; branch_taken = 1'b1;
    data_in = 8'hAD; cycles_req = 3'd4;
    if (PEN) begin
      nx(3, 8'hD0, 8'hBD, NONE);
      page_cross = 1'b1;
      nx(4, 8'hD0, 8'hBD, NONE);
    end
    is_branch = 1'b0; branch_taken = 1'b0; page_cross = 1'b0;
    nx(1, 8'hAD, 8'hD0, NONE);

    // NMI edge in T2 of a 4-cycle instruction
    nx(2, 8'hAD, 8'hD0, NONE);
    NMI_n = 1'b0; data_in = 8'hFF;
    run(3, 4, 8'hAD, 8'hD0, NONE);
    nx(1, 8'h00, 8'hAD, NMI);
    run(2, 7, 8'h00, 8'hAD, NMI);
    NMI_n = 1'b1; data_in = 8'h58; cycles_req = 3'd2;
    nx(1, 8'h58, 8'h00, NONE);

    // masked IRQ, then RDY freeze
    IRQ_n = 1'b0; I_flag = 1'b1;
    nx(2, 8'h58, 8'h00, NONE);
    data_in = 8'hB5; cycles_req = 3'd4;
    nx(1, 8'hB5, 8'h58, NONE);
    nx(2, 8'hB5, 8'h58, NONE);
    RDY = 1'b0;
    run(2, 2, 8'hB5, 8'h58, NONE);
    run(2, 2, 8'hB5, 8'h58, NONE);
    run(2, 2, 8'hB5, 8'h58, NONE);
    RDY = 1'b1;
    run(3, 4, 8'hB5, 8'h58, NONE);

    // unmasked IRQ, NMI edge arrives during it
    I_flag = 1'b0;
    nx(1, 8'h00, 8'hB5, IRQ);
    run(2, 3, 8'h00, 8'hB5, IRQ);
    NMI_n = 1'b0;
    nx(4, 8'h00, 8'hB5, IRQ);
    NMI_n = 1'b1;
    run(5, 7, 8'h00, 8'hB5, IRQ);
    IRQ_n = 1'b1;
    nx(1, 8'h00, 8'h00, NMI);
    run(2, 7, 8'h00, 8'h00, NMI);
    data_in = 8'hE8; cycles_req = 3'd2;
    nx(1, 8'hE8, 8'h00, NONE);
    nx(2, 8'hE8, 8'h00, NONE);

    // NMI edge and IRQ in the same last cycle
    NMI_n = 1'b0; IRQ_n = 1'b0; data_in = 8'hFF;
    nx(1, 8'h00, 8'hE8, NMI);
    run(2, 7, 8'h00, 8'hE8, NMI);
    nx(1, 8'h00, 8'h00, IRQ);
    NMI_n = 1'b1; IRQ_n = 1'b1;
    run(2, 7, 8'h00, 8'h00, IRQ);

    // illegal length, then saturation at 7
    data_in = 8'hC8; cycles_req = 3'd0;
    nx(1, 8'hC8, 8'h00, NONE);
    nx(2, 8'hC8, 8'h00, NONE);
    data_in = 8'hCA; cycles_req = 3'd3;
    nx(1, 8'hCA, 8'hC8, NONE);
    run(2, 3, 8'hCA, 8'hC8, NONE);
    data_in = 8'hBD; cycles_req = 3'd7;
    nx(1, 8'hBD, 8'hCA, NONE);
    run(2, 3, 8'hBD, 8'hCA, NONE);
    page_cross = 1'b1;
    nx(4, 8'hBD, 8'hCA, NONE);
    page_cross = 1'b0;
    run(5, 7, 8'hBD, 8'hCA, NONE);

    // NMI edge captured while RDY is low
    data_in = 8'hEA; cycles_req = 3'd4;
    nx(1, 8'hEA, 8'hBD, NONE);
    nx(2, 8'hEA, 8'hBD, NONE);
    RDY = 1'b0; NMI_n = 1'b0;
    nx(2, 8'hEA, 8'hBD, NONE);
    NMI_n = 1'b1;
    nx(2, 8'hEA, 8'hBD, NONE);
    RDY = 1'b1;
    run(3, 4, 8'hEA, 8'hBD, NONE);
    nx(1, 8'h00, 8'hEA, NMI);
    run(2, 3, 8'h00, 8'hEA, NMI);

    // reset in the middle of the NMI sequence
    @(negedge phi2);
    #1;
    RES_n = 1'b0;
    nx(1, 8'h00, 8'h00, RST);
    nx(1, 8'h00, 8'h00, RST);
    RES_n = 1'b1;
    run(2, 7, 8'h00, 8'h00, RST);
    data_in = 8'hA9; cycles_req = 3'd2;
    nx(1, 8'hA9, 8'h00, NONE);
    nx(2, 8'hA9, 8'h00, NONE);

    for (int i = 0; i < 4 && q.size() > 0; i++)
      @(negedge phi2);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
